// File: rtl/alu_control_pipe_if.sv
// Handshake and decode bus between the control unit, the ALU control pipe and the execute stage.
interface alu_control_pipe_if #(
    parameter int CTRL_W = 4,
    parameter int TAG_W  = 5,
    parameter int ERR_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ALUOp;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] saida;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output in_valid, ALUOp, funct7, funct3, in_tag, out_ready,
        input  in_ready, out_valid, saida, out_illegal, out_tag, err_count
    );

    modport slave (
        input  in_valid, ALUOp, funct7, funct3, in_tag, out_ready,
        output in_ready, out_valid, saida, out_illegal, out_tag, err_count
    );
endinterface

// File: rtl/alu_control_pipe.sv
// Pipelined RISC-V ALU control decoder, STAGES cycles latency, one decode per cycle.
// Backpressure stalls every stage at once while out_valid && !out_ready; flush drops all in-flight entries.
module alu_control_pipe #(
    parameter int STAGES   = 1,
    parameter int CTRL_W   = 4,
    parameter int ENABLE_M = 0,
    parameter int TAG_W    = 5,
    parameter int ERR_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    alu_control_pipe_if.slave bus
);

    localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(4'b1001);

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    logic [CTRL_W-1:0] dec_op;
    logic              dec_ill;

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (bus.ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                case (bus.funct3)
                    3'b000, 3'b001: dec_op = OP_SUB;
                    3'b100, 3'b101: dec_op = OP_SLT;
                    3'b110, 3'b111: dec_op = OP_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                if (bus.funct7 == F7_BASE) begin
                    case (bus.funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (bus.funct7 == F7_ALT) begin
                    case (bus.funct3)
                        3'b000:  dec_op = OP_SUB;
                        3'b101:  dec_op = OP_SRA;
                        default: dec_ill = 1'b1;
                    endcase
                end else if (bus.funct7 == F7_MEXT && ENABLE_M != 0) begin
                    // M ops are 1_0fff: MUL..REMU follow funct3 directly
                    dec_op = CTRL_W'({2'b10, bus.funct3});
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: begin
                case (bus.funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        if (bus.funct7 == F7_BASE) dec_op = OP_SLL;
                        else                       dec_ill = 1'b1;
                    end
                    default: begin
                        if (bus.funct7 == F7_BASE)     dec_op = OP_SRL;
                        else if (bus.funct7 == F7_ALT) dec_op = OP_SRA;
                        else                           dec_ill = 1'b1;
                    end
                endcase
            end
        endcase
        if (dec_ill) dec_op = '0;
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] ill_q;
    logic [CTRL_W-1:0] op_q  [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [ERR_W-1:0]  err_q;
    logic              advance;
    logic              deliver_ill;

    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            ill_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q[0] <= bus.in_valid;
            ill_q[0] <= dec_ill;
            op_q[0]  <= dec_op;
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                ill_q[i] <= ill_q[i-1];
                op_q[i]  <= op_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // A flushed handshake is dropped, so it must not be counted either
    assign deliver_ill = !flush && vld_q[STAGES-1] && bus.out_ready && ill_q[STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (deliver_ill && err_q != {ERR_W{1'b1}}) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign bus.out_valid   = vld_q[STAGES-1];
    assign bus.saida       = op_q[STAGES-1];
    assign bus.out_illegal = ill_q[STAGES-1];
    assign bus.out_tag     = tag_q[STAGES-1];
    assign bus.err_count   = err_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench: DUT a (STAGES=2, M enabled, CTRL_W=5) and DUT b (STAGES=3, M disabled, ERR_W=2).
module tb_alu_control_pipe;

    logic clock = 1'b0;
    logic reset;
    logic flush_a;
    logic flush_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    alu_control_pipe_if #(.CTRL_W(5), .TAG_W(5), .ERR_W(8)) ifa ();
    alu_control_pipe_if #(.CTRL_W(4), .TAG_W(5), .ERR_W(2)) ifb ();

    alu_control_pipe #(.STAGES(2), .CTRL_W(5), .ENABLE_M(1), .TAG_W(5), .ERR_W(8)) u_a (
        .clock (clock),
        .reset (reset),
        .flush (flush_a),
        .bus   (ifa.slave)
    );

    alu_control_pipe #(.STAGES(3), .CTRL_W(4), .ENABLE_M(0), .TAG_W(5), .ERR_W(2)) u_b (
        .clock (clock),
        .reset (reset),
        .flush (flush_b),
        .bus   (ifb.slave)
    );

    typedef struct packed {
        logic [1:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] op;
        logic       ill;
    } vec_t;

    vec_t va [13];

    logic [3:0] mon_op  [$];
    logic [4:0] mon_tag [$];
    logic       mon_ill [$];

    always @(negedge clock) begin
        if (!reset && !flush_b && ifb.out_valid && ifb.out_ready) begin
            mon_op.push_back(ifb.saida);
            mon_tag.push_back(ifb.out_tag);
            mon_ill.push_back(ifb.out_illegal);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        mon_op.delete();
        mon_tag.delete();
        mon_ill.delete();
    endtask

    // Single request through DUT a with an exact two-cycle latency check
    task automatic run_a(input vec_t v, input logic [4:0] tag);
        check("a_in_ready", ifa.in_ready, 1);
        ifa.in_valid = 1'b1;
        ifa.ALUOp    = v.aluop;
        ifa.funct7   = v.f7;
        ifa.funct3   = v.f3;
        ifa.in_tag   = tag;
        @(posedge clock); #1;
        ifa.in_valid = 1'b0;
        check("a_early_valid", ifa.out_valid, 0);
        @(posedge clock); #1;
        check("a_valid", ifa.out_valid, 1);
        check("a_saida", ifa.saida, v.op);
        check("a_illegal", ifa.out_illegal, v.ill);
        check("a_tag", ifa.out_tag, tag);
    endtask

    task automatic push_b(input logic [1:0] aluop, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [4:0] tag);
        bit ok = 1'b0;
        ifb.in_valid = 1'b1;
        ifb.ALUOp    = aluop;
        ifb.funct7   = f7;
        ifb.funct3   = f3;
        ifb.in_tag   = tag;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clock);
            if (ifb.in_ready) ok = 1'b1;
        end
        if (!ok) check("b_push_timeout", 0, 1);
        @(posedge clock); #1;
        ifb.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bp_op [5];
        bp_op = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0001};

        va[0]  = '{2'b10, 7'b0100000, 3'b000, 5'b00110, 1'b0};
        va[1]  = '{2'b10, 7'b0000000, 3'b111, 5'b00000, 1'b0};
        va[2]  = '{2'b10, 7'b0100000, 3'b101, 5'b01001, 1'b0};
        va[3]  = '{2'b01, 7'b1010101, 3'b001, 5'b00110, 1'b0};
        va[4]  = '{2'b01, 7'b0000000, 3'b011, 5'b00000, 1'b1};
        va[5]  = '{2'b11, 7'b0000000, 3'b001, 5'b00011, 1'b0};
        va[6]  = '{2'b11, 7'b0100000, 3'b001, 5'b00000, 1'b1};
        va[7]  = '{2'b10, 7'b0000001, 3'b100, 5'b10100, 1'b0};
        va[8]  = '{2'b00, 7'b1111111, 3'b111, 5'b00010, 1'b0};
        va[9]  = '{2'b11, 7'b0100000, 3'b101, 5'b01001, 1'b0};
        va[10] = '{2'b11, 7'b1111111, 3'b110, 5'b00001, 1'b0};
        va[11] = '{2'b10, 7'b0000010, 3'b000, 5'b00000, 1'b1};
        va[12] = '{2'b10, 7'b0000000, 3'b011, 5'b01000, 1'b0};

        reset   = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.ALUOp = '0; ifa.funct7 = '0; ifa.funct3 = '0; ifa.in_tag = '0;
        ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.ALUOp = '0; ifb.funct7 = '0; ifb.funct3 = '0; ifb.in_tag = '0;
        ifb.out_ready = 1'b1;
        #1;
        check("rst_a_valid", ifa.out_valid, 0);
        check("rst_a_saida", ifa.saida, 0);
        check("rst_a_tag", ifa.out_tag, 0);
        check("rst_a_err", ifa.err_count, 0);
        check("rst_b_valid", ifb.out_valid, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        check("rst_a_in_ready", ifa.in_ready, 1);
        check("rst_b_in_ready", ifb.in_ready, 1);

        for (int i = 0; i < 13; i++) run_a(va[i], 5'(i + 3));
        @(posedge clock); #1;
        check("a_err_count", ifa.err_count, 3);

        // M encoding on a core without M: illegal, three-cycle latency
        mon_clear();
        push_b(2'b10, 7'b0000001, 3'b100, 5'd9);
        check("b_lat0", ifb.out_valid, 0);
        @(posedge clock); #1;
        check("b_lat1", ifb.out_valid, 0);
        @(posedge clock); #1;
        check("b_lat2_valid", ifb.out_valid, 1);
        check("b_m_illegal", ifb.out_illegal, 1);
        check("b_m_saida", ifb.saida, 0);
        check("b_m_tag", ifb.out_tag, 9);
        @(posedge clock); #1;
        check("b_m_err", ifb.err_count, 1);

        // Backpressure: fill the pipe, hold four cycles, then drain
        mon_clear();
        ifb.out_ready = 1'b0;
        push_b(2'b10, 7'b0000000, 3'b000, 5'd1);
        push_b(2'b10, 7'b0000000, 3'b001, 5'd2);
        push_b(2'b10, 7'b0000000, 3'b100, 5'd3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("bp_in_ready", ifb.in_ready, 0);
            check("bp_valid", ifb.out_valid, 1);
            check("bp_hold_tag", ifb.out_tag, 1);
            check("bp_hold_saida", ifb.saida, 4'b0010);
        end
        @(posedge clock); #1;
        ifb.out_ready = 1'b1;
        push_b(2'b10, 7'b0000000, 3'b101, 5'd4);
        push_b(2'b10, 7'b0000000, 3'b110, 5'd5);
        repeat (6) @(posedge clock);
        #1;
        check("bp_count", mon_tag.size(), 5);
        for (int i = 0; i < 5 && i < mon_tag.size(); i++) begin
            check("bp_tag", mon_tag[i], i + 1);
            check("bp_saida", mon_op[i], bp_op[i]);
        end
        check("bp_err", ifb.err_count, 1);

        // Flush while an illegal result is presented and two more are in flight
        mon_clear();
        push_b(2'b01, 7'b0000000, 3'b010, 5'd6);
        push_b(2'b01, 7'b0000000, 3'b010, 5'd7);
        push_b(2'b01, 7'b0000000, 3'b010, 5'd8);
        check("fl_pre_valid", ifb.out_valid, 1);
        flush_b = 1'b1;
        @(negedge clock);
        check("fl_in_ready", ifb.in_ready, 0);
        @(posedge clock); #1;
        flush_b = 1'b0;
        check("fl_valid", ifb.out_valid, 0);
        check("fl_err", ifb.err_count, 1);
        repeat (4) @(posedge clock);
        #1;
        check("fl_valid_later", ifb.out_valid, 0);
        check("fl_delivered", mon_tag.size(), 0);
        check("fl_err_later", ifb.err_count, 1);

        // Saturation of a 2-bit counter
        mon_clear();
        for (int i = 0; i < 5; i++) push_b(2'b01, 7'b0000000, 3'b011, 5'(10 + i));
        repeat (6) @(posedge clock);
        #1;
        check("sat_count", mon_tag.size(), 5);
        check("sat_err", ifb.err_count, 3);

        // Asynchronous reset during a stall
        ifb.out_ready = 1'b0;
        push_b(2'b11, 7'b0000000, 3'b100, 5'd20);
        push_b(2'b11, 7'b0000000, 3'b110, 5'd21);
        push_b(2'b11, 7'b0000000, 3'b111, 5'd22);
        check("mr_pre_valid", ifb.out_valid, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mr_valid", ifb.out_valid, 0);
        check("mr_err", ifb.err_count, 0);
        check("mr_saida", ifb.saida, 0);
        check("mr_tag", ifb.out_tag, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("mr_in_ready", ifb.in_ready, 1);
        check("mr_valid_after", ifb.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
